// File: rtl/hs32_fetch.sv
// HS32 instruction fetch stage: owns the PC, issues single-outstanding word reads
// and buffers returned words in a prefetch FIFO toward decode.
module hs32_fetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] addr,
  output logic        reqm,
  input  logic [31:0] dtrm,
  input  logic        ackm,
  input  logic        flush,
  input  logic [31:0] newpc,
  output logic [31:0] instd,
  output logic [31:0] pcd,
  output logic        reqd,
  input  logic        rdyd
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     addr_q, addr_d;
  logic            reqm_q, reqm_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     mem_pc_q   [DEPTH];
  logic [31:0]     mem_pc_d   [DEPTH];
  logic [31:0]     mem_inst_q [DEPTH];
  logic [31:0]     mem_inst_d [DEPTH];
  logic            push;
  logic            pop;
  logic [31:0]     pc_inc;

  // Next-state, PC, request and FIFO bookkeeping
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    reqm_d     = reqm_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    mem_pc_d   = mem_pc_q;
    mem_inst_d = mem_inst_q;
    pop        = (cnt_q != '0) && rdyd && !flush;
    push       = (state_q == S_FETCH) && ackm && !flush;
    pc_inc     = pc_q + 32'd4;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      pc_d     = newpc & 32'hFFFF_FFFC;
      reqm_d   = 1'b1;
      // An un-acked request cannot be cancelled; wait it out in DRAIN
      if ((state_q != S_IDLE) && !ackm) begin
        state_d = S_DRAIN;
      end else begin
        state_d = S_FETCH;
        addr_d  = pc_d;
      end
    end else begin
      if (push) begin
        mem_pc_d[wr_ptr_q]   = pc_q;
        mem_inst_d[wr_ptr_q] = dtrm;
        wr_ptr_d             = wr_ptr_q + AW'(1);
        pc_d                 = pc_inc;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      cnt_d = cnt_q + CW'(push) - CW'(pop);

      case (state_q)
        S_IDLE: begin
          if (cnt_d < CW'(DEPTH)) begin
            state_d = S_FETCH;
            reqm_d  = 1'b1;
            addr_d  = pc_q;
          end
        end
        S_FETCH: begin
          if (ackm) begin
            addr_d = pc_inc;
            if (cnt_d < CW'(DEPTH)) begin
              reqm_d = 1'b1;
            end else begin
              state_d = S_IDLE;
              reqm_d  = 1'b0;
            end
          end
        end
        S_DRAIN: begin
          if (ackm) begin
            state_d = S_FETCH;
            reqm_d  = 1'b1;
            addr_d  = pc_q;
          end
        end
        default: begin
          state_d = S_IDLE;
          reqm_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      reqm_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_pc_q[i]   <= '0;
        mem_inst_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      reqm_q     <= reqm_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      mem_pc_q   <= mem_pc_d;
      mem_inst_q <= mem_inst_d;
    end
  end

  assign addr  = addr_q;
  assign reqm  = reqm_q;
  assign reqd  = (cnt_q != '0);
  assign instd = mem_inst_q[rd_ptr_q];
  assign pcd   = mem_pc_q[rd_ptr_q];

endmodule

// File: tb/tb_hs32_fetch.sv
// Self-checking bench for hs32_fetch: queue-based reference model compared every
// cycle, plus directed literal expectations for each scenario.
module tb_hs32_fetch;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] XORV  = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, dtrm, newpc, instd, pcd;
  logic        reqm, ackm, flush, reqd, rdyd;
  logic [31:0] addr_w, instd_w, pcd_w;
  logic        reqm_w, reqd_w;

  int n_checks = 0;
  int n_pass   = 0;
  int ack_delay = 0;
  int wait_cnt  = 0;
  int acks      = 0;
  bit auto_ack  = 1'b1;

  hs32_fetch #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .addr(addr), .reqm(reqm), .dtrm(dtrm), .ackm(ackm),
    .flush(flush), .newpc(newpc), .instd(instd), .pcd(pcd), .reqd(reqd), .rdyd(rdyd)
  );

  hs32_fetch #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .reset(reset), .addr(addr_w), .reqm(reqm_w), .dtrm(dtrm), .ackm(ackm),
    .flush(flush), .newpc(newpc), .instd(instd_w), .pcd(pcd_w), .reqd(reqd_w), .rdyd(rdyd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: queue of fetched words, one outstanding request
  logic [31:0] q_pc[$];
  logic [31:0] q_inst[$];
  logic [31:0] m_pc, m_req_addr;
  bit          m_busy, m_discard;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q_pc.delete();
      q_inst.delete();
      m_pc       = 32'h0;
      m_req_addr = 32'h0;
      m_busy     = 1'b0;
      m_discard  = 1'b0;
    end else begin
      bit do_pop;
      do_pop = (q_pc.size() > 0) && rdyd && !flush;
      if (flush) begin
        q_pc.delete();
        q_inst.delete();
        m_pc = {newpc[31:2], 2'b00};
        if (m_busy && !ackm) begin
          m_discard = 1'b1;
        end else begin
          m_busy     = 1'b1;
          m_discard  = 1'b0;
          m_req_addr = m_pc;
        end
      end else begin
        if (m_busy && ackm) begin
          if (!m_discard) begin
            q_pc.push_back(m_req_addr);
            q_inst.push_back(dtrm);
            m_pc = m_req_addr + 32'd4;
          end
          m_busy    = 1'b0;
          m_discard = 1'b0;
        end
        if (do_pop) begin
          void'(q_pc.pop_front());
          void'(q_inst.pop_front());
        end
        if (!m_busy && q_pc.size() < int'(DEPTH)) begin
          m_busy     = 1'b1;
          m_req_addr = m_pc;
        end
      end
    end
  end

  // Every-cycle comparison of the primary DUT against the model
  always @(negedge clk) begin
    if (!reset) begin
      chk("model reqm", 32'(reqm), 32'(m_busy));
      chk("model addr", addr, m_busy ? m_req_addr : m_pc);
      chk("model reqd", 32'(reqd), 32'(q_pc.size() != 0));
      if (q_pc.size() != 0) begin
        chk("model pcd", pcd, q_pc[0]);
        chk("model instd", instd, q_inst[0]);
      end
    end
  end

  // One cycle: wait for the falling edge, then the memory responder drives ackm/dtrm
  task automatic tick();
    @(negedge clk);
    flush = 1'b0;
    if (auto_ack && reqm && !reset) begin
      if (wait_cnt >= ack_delay) begin
        ackm     = 1'b1;
        wait_cnt = 0;
        acks++;
      end else begin
        ackm = 1'b0;
        wait_cnt++;
      end
    end else begin
      ackm = 1'b0;
    end
    dtrm = addr ^ XORV;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    ackm     = 1'b0;
    flush    = 1'b0;
    wait_cnt = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; rdyd = 1'b1; flush = 1'b0; ackm = 1'b0; newpc = 32'h0; dtrm = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst reqm", 32'(reqm), 32'h0);
    chk("rst addr", addr, 32'h0);
    chk("rst reqd", 32'(reqd), 32'h0);
    chk("rst instd", instd, 32'h0);
    chk("rst pcd", pcd, 32'h0);
    chk("rst addr_w", addr_w, 32'hFFFF_FFF8);
    reset = 1'b0;

    // Streaming with ack every cycle and decode always ready
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("seq reqm", 32'(reqm), 32'h1);
      chk("seq addr", addr, 32'(i * 4));
      if (i > 0) begin
        chk("seq reqd", 32'(reqd), 32'h1);
        chk("seq pcd", pcd, 32'((i - 1) * 4));
        chk("seq instd", instd, 32'((i - 1) * 4) ^ XORV);
      end
    end

    // Backpressure: fill the FIFO, then a single pop re-enables fetch
    rdyd = 1'b0;
    do_reset();
    acks = 0;
    for (int i = 0; i < 8; i++) tick();
    chk("bp acks", 32'(acks), 32'd4);
    chk("bp reqm", 32'(reqm), 32'h0);
    chk("bp addr", addr, 32'h10);
    chk("bp pcd", pcd, 32'h0);
    rdyd = 1'b1;
    tick();
    rdyd = 1'b0;
    chk("bp reqm after pop", 32'(reqm), 32'h1);
    chk("bp addr after pop", addr, 32'h10);
    chk("bp pcd after pop", pcd, 32'h4);
    repeat (3) tick();

    // Flush while the request at 0x8 is waiting for a slow ack
    rdyd = 1'b1; ack_delay = 0;
    do_reset();
    tick(); tick();
    ack_delay = 3;
    tick();
    chk("drain addr0", addr, 32'h8);
    flush = 1'b1; newpc = 32'h0000_1003;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("drain reqd", 32'(reqd), 32'h0);
      chk("drain reqm", 32'(reqm), 32'h1);
      chk("drain addr", addr, 32'h8);
    end
    chk("drain ack", 32'(ackm), 32'h1);
    ack_delay = 0;
    tick();
    chk("drain next addr", addr, 32'h1000);
    chk("drain reqd after", 32'(reqd), 32'h0);
    tick();
    chk("drain first pcd", pcd, 32'h1000);
    chk("drain first instd", instd, 32'h1000 ^ XORV);
    repeat (2) tick();

    // Flush coinciding with the ack of 0x4
    do_reset();
    tick(); tick();
    chk("fa addr", addr, 32'h4);
    chk("fa ack", 32'(ackm), 32'h1);
    flush = 1'b1; newpc = 32'h200;
    tick();
    chk("fa next addr", addr, 32'h200);
    chk("fa reqd", 32'(reqd), 32'h0);
    tick();
    chk("fa pcd", pcd, 32'h200);
    repeat (2) tick();

    // Flush with decode ready and a full FIFO
    rdyd = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) tick();
    chk("ff reqd before", 32'(reqd), 32'h1);
    rdyd = 1'b1; flush = 1'b1; newpc = 32'h300;
    tick();
    chk("ff reqd", 32'(reqd), 32'h0);
    chk("ff addr", addr, 32'h300);
    tick();
    chk("ff pcd", pcd, 32'h300);
    repeat (2) tick();

    // PC wrap on the second instance, then async reset mid-fetch
    do_reset();
    tick(); chk("wrap addr0", addr_w, 32'hFFFF_FFF8);
    tick(); chk("wrap addr1", addr_w, 32'hFFFF_FFFC);
    tick(); chk("wrap addr2", addr_w, 32'h0000_0000);
    chk("wrap pcd", pcd_w, 32'hFFFF_FFFC);
    tick();
    chk("ar reqm before", 32'(reqm), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("ar reqm", 32'(reqm), 32'h0);
    chk("ar reqd", 32'(reqd), 32'h0);
    chk("ar reqm_w", 32'(reqm_w), 32'h0);
    chk("ar reqd_w", 32'(reqd_w), 32'h0);
    chk("ar addr_w", addr_w, 32'hFFFF_FFF8);

    // Stray ack while idle right after reset is ignored
    auto_ack = 1'b0;
    @(negedge clk);
    reset = 1'b0; ackm = 1'b1; dtrm = 32'hDEAD_BEEF;
    @(negedge clk);
    ackm = 1'b0;
    chk("idle ack reqd", 32'(reqd), 32'h0);
    chk("idle ack addr", addr, 32'h0);
    auto_ack = 1'b1;
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
